// File: rtl/apb_controller.sv
// APB master sequencer for the AHB-to-APB bridge: turns each accepted AHB
// address phase into an APB SETUP/ACCESS pair and stalls AHB while in flight.
module apb_controller (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        valid,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [2:0]  temp_selx,
    input  logic [31:0] prdata,
    output logic        pwrite,
    output logic        penable,
    output logic [2:0]  pselx,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        hr_readyout,
    output logic [31:0] hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WENABLE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_pwdata;
    logic [31:0] r_hrdata;
    logic [2:0]  r_sel;
    logic        r_wr;
    logic        w_ready;
    logic        w_accept;
    logic        w_sel_on;

    // Ready is only high in states that can take a new address phase.
    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RENABLE) ||
                      (r_state == ST_WENABLE);
    assign w_accept = valid && w_ready;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_pwdata <= '0;
            r_hrdata <= '0;
            r_sel    <= '0;
            r_wr     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= haddr;
                r_sel  <= temp_selx;
                r_wr   <= hwrite;
            end
            // AHB write data arrives one cycle after its address phase.
            if (r_state == ST_WWAIT)
                r_pwdata <= hwdata;
            if (r_state == ST_RENABLE)
                r_hrdata <= prdata;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        unique case (r_state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite)
                    w_next = ST_READ;
                else if (valid && hwrite)
                    w_next = ST_WWAIT;
                else
                    w_next = ST_IDLE;
            end
            ST_READ:  w_next = ST_RENABLE;
            ST_WWAIT: w_next = ST_WRITE;
            ST_WRITE: w_next = ST_WENABLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_sel_on = (r_state == ST_READ)  || (r_state == ST_RENABLE) ||
                      (r_state == ST_WRITE) || (r_state == ST_WENABLE);

    assign pselx       = w_sel_on ? r_sel : 3'b000;
    assign penable     = (r_state == ST_RENABLE) || (r_state == ST_WENABLE);
    assign pwrite      = (r_state == ST_WRITE)   || (r_state == ST_WENABLE);
    assign hr_readyout = w_ready;
    assign paddr       = r_addr;
    assign pwdata      = r_pwdata;
    // Read data flows through combinationally during the ACCESS cycle.
    assign hrdata      = (r_state == ST_RENABLE) ? prdata : r_hrdata;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: reset, single write/read, back-to-back
// reads, read-then-write, zero select and reset mid-transfer.
module tb_apb_controller;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        valid;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  temp_selx;
    logic [31:0] prdata;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hr_readyout;
    logic [31:0] hrdata;

    int n_tests = 0;
    int n_fail  = 0;

    apb_controller dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .valid       (valid),
        .hwrite      (hwrite),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .temp_selx   (temp_selx),
        .prdata      (prdata),
        .pwrite      (pwrite),
        .penable     (penable),
        .pselx       (pselx),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .hr_readyout (hr_readyout),
        .hrdata      (hrdata)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // ctrl = {pselx, pwrite, penable, hr_readyout}
    task automatic chk_ctrl(input string tag, input logic [2:0] sel, input logic wr,
                            input logic en, input logic rdy);
        chk({tag, ".ctrl"}, {26'd0, pselx, pwrite, penable, hr_readyout},
            {26'd0, sel, wr, en, rdy});
    endtask

    initial begin
        hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0;
        hwdata = '0; temp_selx = '0; prdata = 32'h0000_1234;
        tick(); tick();
        hreset = 1'b0;
        tick();
        chk_ctrl("reset", 3'b000, 1'b0, 1'b0, 1'b1);
        chk("reset.paddr",  paddr,  32'h0);
        chk("reset.pwdata", pwdata, 32'h0);
        chk("reset.hrdata", hrdata, 32'h0);
        tick();
        chk_ctrl("idle_hold", 3'b000, 1'b0, 1'b0, 1'b1);

        // Single write
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0010; temp_selx = 3'b001;
        tick();
        chk_ctrl("wr.wwait", 3'b000, 1'b0, 1'b0, 1'b0);
        valid = 1'b0; hwrite = 1'b0; haddr = 32'h1111_1111; hwdata = 32'hDEAD_BEEF;
        tick();
        chk_ctrl("wr.setup", 3'b001, 1'b1, 1'b0, 1'b0);
        chk("wr.setup.paddr",  paddr,  32'h8000_0010);
        chk("wr.setup.pwdata", pwdata, 32'hDEAD_BEEF);
        hwdata = 32'h0;
        tick();
        chk_ctrl("wr.access", 3'b001, 1'b1, 1'b1, 1'b1);
        tick();
        chk_ctrl("wr.idle", 3'b000, 1'b0, 1'b0, 1'b1);
        chk("wr.idle.pwdata", pwdata, 32'hDEAD_BEEF);
        chk("wr.idle.paddr",  paddr,  32'h8000_0010);

        // Single read
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8400_0004; temp_selx = 3'b010;
        prdata = 32'h0000_0025;
        tick();
        chk_ctrl("rd.setup", 3'b010, 1'b0, 1'b0, 1'b0);
        chk("rd.setup.paddr", paddr, 32'h8400_0004);
        valid = 1'b0;
        tick();
        chk_ctrl("rd.access", 3'b010, 1'b0, 1'b1, 1'b1);
        chk("rd.access.hrdata", hrdata, 32'h0000_0025);
        tick();
        prdata = 32'hFFFF_0000;
        #1;
        chk_ctrl("rd.idle", 3'b000, 1'b0, 1'b0, 1'b1);
        chk("rd.hold.hrdata", hrdata, 32'h0000_0025);

        // Back-to-back reads; valid during SETUP must be ignored
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0000; temp_selx = 3'b001;
        tick();
        chk_ctrl("b2b.s0", 3'b001, 1'b0, 1'b0, 1'b0);
        chk("b2b.s0.paddr", paddr, 32'h8000_0000);
        haddr = 32'h8000_0004;
        tick();
        chk_ctrl("b2b.a0", 3'b001, 1'b0, 1'b1, 1'b1);
        chk("b2b.a0.paddr", paddr, 32'h8000_0000);
        tick();
        chk_ctrl("b2b.s1", 3'b001, 1'b0, 1'b0, 1'b0);
        chk("b2b.s1.paddr", paddr, 32'h8000_0004);
        haddr = 32'h8000_0008; temp_selx = 3'b100;
        tick();
        chk_ctrl("b2b.a1", 3'b001, 1'b0, 1'b1, 1'b1);
        chk("b2b.a1.paddr", paddr, 32'h8000_0004);
        tick();
        chk_ctrl("b2b.s2", 3'b100, 1'b0, 1'b0, 1'b0);
        chk("b2b.s2.paddr", paddr, 32'h8000_0008);
        valid = 1'b0; prdata = 32'h0000_00AB;
        tick();
        chk_ctrl("b2b.a2", 3'b100, 1'b0, 1'b1, 1'b1);
        chk("b2b.a2.hrdata", hrdata, 32'h0000_00AB);

        // Write presented during the read ACCESS
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8C00_0000; temp_selx = 3'b010;
        tick();
        chk_ctrl("rw.wwait", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("rw.wwait.hrdata", hrdata, 32'h0000_00AB);
        valid = 1'b0; hwrite = 1'b0; hwdata = 32'h5555_AAAA; prdata = 32'h0;
        tick();
        chk_ctrl("rw.setup", 3'b010, 1'b1, 1'b0, 1'b0);
        chk("rw.setup.paddr",  paddr,  32'h8C00_0000);
        chk("rw.setup.pwdata", pwdata, 32'h5555_AAAA);

        // Reset during write SETUP: no ACCESS follows
        hreset = 1'b1;
        tick();
        chk_ctrl("rst_mid", 3'b000, 1'b0, 1'b0, 1'b1);
        chk("rst_mid.pwdata", pwdata, 32'h0);
        chk("rst_mid.paddr",  paddr,  32'h0);
        chk("rst_mid.hrdata", hrdata, 32'h0);
        hreset = 1'b0;
        tick();
        chk_ctrl("rst_mid.after", 3'b000, 1'b0, 1'b0, 1'b1);

        // Zero select is still sequenced, pselx stays 0
        valid = 1'b1; hwrite = 1'b0; haddr = 32'hF000_0000; temp_selx = 3'b000;
        prdata = 32'h0000_0077;
        tick();
        chk_ctrl("nosel.setup", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("nosel.paddr", paddr, 32'hF000_0000);
        valid = 1'b0;
        tick();
        chk_ctrl("nosel.access", 3'b000, 1'b0, 1'b1, 1'b1);
        chk("nosel.hrdata", hrdata, 32'h0000_0077);
        tick();
        chk_ctrl("nosel.idle", 3'b000, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
